// File: rtl/ls_queue_pkg.sv
// Shared types and constants for the load/store queue: data/address types,
// access direction codes, FSM state encoding and the packed queue entry.
package ls_queue_pkg;

   typedef logic [31:0] word_t;
   typedef logic [31:0] addr_t;
   typedef logic [7:0]  byte_t;

   localparam logic READ_SIGNAL  = 1'b0;
   localparam logic WRITE_SIGNAL = 1'b1;
   localparam int   NULL_PTR     = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   typedef struct packed {
      logic  oper;
      addr_t addr;
      byte_t size;
      word_t data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   // Byte count actually performed; anything other than 2 or 4 is one byte.
   function automatic logic [2:0] eff_size(input byte_t sz);
      logic [2:0] n;
      case (sz)
         8'd2:    n = 3'd2;
         8'd4:    n = 3'd4;
         default: n = 3'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ls_fifo.sv
// Circular entry store for the load/store queue. Pushes while full are
// dropped; pointers wrap naturally because DEPTH is a power of two.
module ls_fifo
   import ls_queue_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ENTRY_W-1:0]       din,
   output logic [ENTRY_W-1:0]       head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               do_push, do_pop;

   // Accept/retire decisions and next pointer/count values.
   always_comb begin
      do_push  = push && (count_q < FULL);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
   end

   // Pointer and occupancy registers; frozen while rdy is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= PTR_W'(NULL_PTR);
         rd_ptr_q <= PTR_W'(NULL_PTR);
         count_q  <= '0;
      end else if (rdy) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; only pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (rdy && do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: buffers requests in ls_fifo and sequences them
// byte by byte onto a synchronous single-port byte RAM.
module ls_queue
   import ls_queue_pkg::*;
#(
   parameter int QUEUE_SIZE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   input  logic       en_ls,
   input  logic       ls_oper,
   input  addr_t      ls_addr,
   input  byte_t      ls_size,
   input  word_t      ls_data,
   output word_t      qsize,
   output logic       finish,
   output word_t      ls_data_out,
   input  logic [7:0] mem_din,
   output logic [7:0] mem_dout,
   output addr_t      mem_a,
   output logic       mem_wr
);

   localparam int CNT_W = $clog2(QUEUE_SIZE) + 1;

   logic [CNT_W-1:0]   count;
   logic [ENTRY_W-1:0] push_bits, head_bits;
   entry_t             head;
   logic               pop;
   logic [2:0]         hsize;
   logic [2:0]         rd_idx;

   state_t state_q, state_d;
   logic [2:0] idx_q, idx_d;
   word_t      acc_q, acc_d;
   word_t      data_out_q, data_out_d;
   logic       finish_q, finish_d;

   assign push_bits = {ls_oper, ls_addr, ls_size, ls_data};
   assign head      = entry_t'(head_bits);
   assign hsize     = eff_size(head.size);
   assign qsize     = {{(32 - CNT_W){1'b0}}, count};

   ls_fifo #(.DEPTH(QUEUE_SIZE)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .push  (en_ls),
      .pop   (pop),
      .din   (push_bits),
      .head  (head_bits),
      .count (count)
   );

   // FSM state, byte index, load accumulator and registered load result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         acc_q      <= '0;
         data_out_q <= '0;
         finish_q   <= 1'b0;
      end else if (rdy) begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         data_out_q <= data_out_d;
         finish_q   <= finish_d;
      end
   end

   // Next state: READ runs size+1 cycles because the RAM answers one cycle
   // after each address, so idx doubles as "bytes sampled so far + 1".
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      data_out_d = data_out_q;
      finish_d   = 1'b0;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count != '0) begin
               state_d = (head.oper == WRITE_SIGNAL) ? ST_WRITE : ST_READ;
               idx_d   = 3'd0;
               acc_d   = '0;
            end
         end
         ST_WRITE: begin
            if (idx_q == hsize - 3'd1) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
               idx_d   = 3'd0;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         ST_READ: begin
            if (idx_q != 3'd0) begin
               acc_d = {acc_q[23:0], mem_din};
            end
            if (idx_q == hsize) begin
               pop        = 1'b1;
               finish_d   = 1'b1;
               data_out_d = {acc_q[23:0], mem_din};
               state_d    = ST_IDLE;
               idx_d      = 3'd0;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // RAM-side outputs decoded from state; the final read cycle only samples,
   // so the address stays on the last byte rather than running past it.
   always_comb begin
      mem_wr   = 1'b0;
      mem_a    = '0;
      mem_dout = '0;
      rd_idx   = (idx_q == hsize) ? idx_q - 3'd1 : idx_q;
      case (state_q)
         ST_WRITE: begin
            mem_wr   = 1'b1;
            mem_a    = head.addr + {29'd0, idx_q};
            mem_dout = head.data[{idx_q[1:0], 3'b000} +: 8];
         end
         ST_READ: begin
            mem_a = head.addr + {29'd0, rd_idx};
         end
         default: ;
      endcase
   end

   assign finish      = finish_q;
   assign ls_data_out = data_out_q;

endmodule

// File: tb/tb_ls_queue.sv
// Directed bench for ls_queue with a synchronous byte RAM model.
module tb_ls_queue;

   logic        clk = 1'b0;
   logic        rst, rdy, en_ls, ls_oper;
   logic [31:0] ls_addr, ls_data;
   logic [7:0]  ls_size;
   logic [31:0] qsize, ls_data_out, mem_a;
   logic        finish, mem_wr;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;

   bit   [7:0]  ram [4096];
   logic [31:0] wr_a [$];
   logic [7:0]  wr_d [$];

   int errors = 0;
   int checks = 0;

   ls_queue #(.QUEUE_SIZE(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .en_ls       (en_ls),
      .ls_oper     (ls_oper),
      .ls_addr     (ls_addr),
      .ls_size     (ls_size),
      .ls_data     (ls_data),
      .qsize       (qsize),
      .finish      (finish),
      .ls_data_out (ls_data_out),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout),
      .mem_a       (mem_a),
      .mem_wr      (mem_wr)
   );

   always #5 clk = ~clk;

   // Byte RAM, one-cycle read latency, stalled together with the queue.
   always @(posedge clk) begin
      if (rdy === 1'b1) begin
         if (mem_wr === 1'b1) ram[mem_a[11:0]] <= mem_dout;
         mem_din <= ram[mem_a[11:0]];
      end
   end

   // Log of every byte write strobe.
   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         wr_a.push_back(mem_a);
         wr_d.push_back(mem_dout);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic op, input logic [31:0] a, input logic [7:0] sz,
                       input logic [31:0] d);
      en_ls   = 1'b1;
      ls_oper = op;
      ls_addr = a;
      ls_size = sz;
      ls_data = d;
      step();
      en_ls = 1'b0;
   endtask

   task automatic wait_finish(input string tag, input logic [31:0] exp);
      int n = 0;
      while (finish !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk({tag, "_fin"}, {31'd0, finish}, 32'd1);
      chk({tag, "_data"}, ls_data_out, exp);
      step();
      chk({tag, "_pulse"}, {31'd0, finish}, 32'd0);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((qsize !== 32'd0 || mem_wr !== 1'b0) && n < 300) begin
         step();
         n++;
      end
      chk({tag, "_drain"}, (n < 300) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int s;
      rst = 1'b0; rdy = 1'b1; en_ls = 1'b0; ls_oper = 1'b0;
      ls_addr = '0; ls_size = '0; ls_data = '0;
      repeat (2) step();
      chk("rst_qsize", qsize, 32'd0);
      chk("rst_finish", {31'd0, finish}, 32'd0);
      chk("rst_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_out", ls_data_out, 32'd0);
      rst = 1'b1;
      repeat (2) step();

      // Word store, byte sequence little-endian
      push(1'b1, 32'h100, 8'd4, 32'h11223344);
      chk("sw_q1", qsize, 32'd1);
      chk("sw_latency", {31'd0, mem_wr}, 32'd0);
      step();
      chk("sw_b0", {mem_wr, 15'd0, mem_a[7:0], mem_dout}, {1'b1, 15'd0, 8'h00, 8'h44});
      chk("sw_a0", mem_a, 32'h100);
      step();
      chk("sw_b1", {mem_wr, 15'd0, mem_a[15:0]}, {1'b1, 15'd0, 16'h0101});
      chk("sw_d1", {24'd0, mem_dout}, 32'h33);
      step();
      chk("sw_a2", mem_a, 32'h102);
      chk("sw_d2", {24'd0, mem_dout}, 32'h22);
      step();
      chk("sw_a3", mem_a, 32'h103);
      chk("sw_d3", {24'd0, mem_dout}, 32'h11);
      chk("sw_q_hold", qsize, 32'd1);
      step();
      chk("sw_idle_wr", {31'd0, mem_wr}, 32'd0);
      chk("sw_idle_a", mem_a, 32'd0);
      chk("sw_q0", qsize, 32'd0);

      // Preload 0x200.. with AA BB CC DD, then reads of each size
      push(1'b1, 32'h200, 8'd4, 32'hDDCCBBAA);
      wait_drain("pre");
      step();
      push(1'b0, 32'h200, 8'd4, 32'h0);
      wait_finish("rd4", 32'hAABBCCDD);
      push(1'b0, 32'h200, 8'd2, 32'h0);
      wait_finish("rd2", 32'h0000AABB);
      push(1'b0, 32'h200, 8'd1, 32'h0);
      wait_finish("rd1", 32'h000000AA);
      push(1'b0, 32'h200, 8'd3, 32'h0);
      wait_finish("rd3", 32'h000000AA);
      push(1'b0, 32'h200, 8'd0, 32'h0);
      wait_finish("rd0", 32'h000000AA);

      // Fill: 19 pushes against a drain of one word store per 5 cycles
      // reaches 16 entries; the 20th push is dropped.
      s = wr_a.size();
      for (int k = 0; k < 20; k++) begin
         en_ls   = 1'b1;
         ls_oper = 1'b1;
         ls_addr = 32'h500 + 32'(4 * k);
         ls_size = 8'd4;
         ls_data = {4{k[7:0]}};
         step();
         if (k == 18) chk("full_q16", qsize, 32'd16);
      end
      en_ls = 1'b0;
      chk("drop_q16", qsize, 32'd16);
      wait_drain("fill");
      chk("fill_bytes", 32'(wr_a.size() - s), 32'd76);
      for (int k = 0; k < 19; k++) begin
         chk("ord_a", wr_a[s + 4 * k + 3], 32'h503 + 32'(4 * k));
         chk("ord_d", {24'd0, wr_d[s + 4 * k]}, 32'(k));
      end
      step();

      // Store then dependent load on the next cycle
      push(1'b1, 32'h300, 8'd1, 32'h0000005A);
      push(1'b0, 32'h300, 8'd1, 32'h0);
      wait_finish("raw", 32'h0000005A);

      // Reset during byte 2 of a word store
      push(1'b1, 32'h600, 8'd4, 32'h11223344);
      repeat (3) step();
      chk("rw_a2", mem_a, 32'h602);
      rst = 1'b0;
      #1;
      chk("rw_wr", {31'd0, mem_wr}, 32'd0);
      chk("rw_a", mem_a, 32'd0);
      chk("rw_dout", {24'd0, mem_dout}, 32'd0);
      chk("rw_q", qsize, 32'd0);
      chk("rw_out", ls_data_out, 32'd0);
      repeat (2) step();
      rst = 1'b1;
      s = wr_a.size();
      repeat (8) step();
      chk("rw_nowr", 32'(wr_a.size() - s), 32'd0);
      chk("rw_b2", {24'd0, ram[12'h602]}, 32'd0);
      chk("rw_b3", {24'd0, ram[12'h603]}, 32'd0);
      chk("rw_q_after", qsize, 32'd0);

      // Stall three cycles in the middle of a read
      push(1'b0, 32'h200, 8'd4, 32'h0);
      repeat (2) step();
      chk("st_a", mem_a, 32'h201);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_hold_a", mem_a, 32'h201);
         chk("st_nofin", {31'd0, finish}, 32'd0);
      end
      rdy = 1'b1;
      wait_finish("st", 32'hAABBCCDD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
